// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Write-port arbiter and long-op scoreboard placed directly in front of the
//   register file write port. Merges the in-order MEM/WB writeback with
//   results from a multicycle long-op unit (mul/div). Long-op results are
//   queued in a small FIFO and written when the pipeline leaves the port free.
//   A starvation FSM forces a drain after too many blocked cycles. A busy
//   scoreboard tracks outstanding long-op destinations and stalls decode on
//   RAW/WAW hazards against them.
//
// Optional feature (compile-time macro WB_BYPASS_EN):
//   When defined, an accepted long-op result skips the FIFO and is written at
//   the next edge if the FIFO is empty, the FSM is NORMAL and the pipeline
//   does not win that cycle. When undefined, every result goes through the
//   FIFO.
//
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   pipe_wen/pipe_wsel/pipe_wdat pipeline writeback request (wsel=0 ignored)
//   lop_issue/lop_dest           long-op issue, marks lop_dest busy
//   lop_valid/lop_ready          long-op result handshake
//   lop_rsel/lop_rdat            long-op result destination/data
//   chk_rs/chk_rt/chk_rd/chk_rd_en  decode operands for hazard check
//   stall                        combinational decode stall
//   rf_wen/rf_wsel/rf_wdat       registered register file write port
//   busy                         scoreboard bit vector
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int NREGS      = 32,
  parameter int WIDTH      = 32,
  parameter int PEND_DEPTH = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      pipe_wen,
  input  logic [$clog2(NREGS)-1:0]  pipe_wsel,
  input  logic [WIDTH-1:0]          pipe_wdat,
  input  logic                      lop_issue,
  input  logic [$clog2(NREGS)-1:0]  lop_dest,
  input  logic                      lop_valid,
  output logic                      lop_ready,
  input  logic [$clog2(NREGS)-1:0]  lop_rsel,
  input  logic [WIDTH-1:0]          lop_rdat,
  input  logic [$clog2(NREGS)-1:0]  chk_rs,
  input  logic [$clog2(NREGS)-1:0]  chk_rt,
  input  logic [$clog2(NREGS)-1:0]  chk_rd,
  input  logic                      chk_rd_en,
  output logic                      stall,
  output logic                      rf_wen,
  output logic [$clog2(NREGS)-1:0]  rf_wsel,
  output logic [WIDTH-1:0]          rf_wdat,
  output logic [NREGS-1:0]          busy
);

  localparam int SELW = $clog2(NREGS);
  localparam int PW   = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
  localparam int CW   = $clog2(PEND_DEPTH + 1);
  localparam int SCW  = $clog2(STARVE_MAX + 1);

  localparam logic [CW-1:0]   DEPTH_C  = CW'(PEND_DEPTH);
  localparam logic [SCW-1:0]  STARVE_C = SCW'(STARVE_MAX);
  localparam logic [SELW-1:0] SEL_ZERO = {SELW{1'b0}};

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_DRAIN  = 1'b1
  } state_e;

  // Scoreboard lookup; register 0 is never considered busy.
  function automatic logic busy_hit(input logic [SELW-1:0] sel,
                                    input logic [NREGS-1:0] vec);
    return (sel != SEL_ZERO) && vec[sel];
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [SCW-1:0]    starve_q, starve_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [SELW-1:0]   fifo_sel_q [PEND_DEPTH];
  logic [SELW-1:0]   fifo_sel_d [PEND_DEPTH];
  logic [WIDTH-1:0]  fifo_dat_q [PEND_DEPTH];
  logic [WIDTH-1:0]  fifo_dat_d [PEND_DEPTH];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic              rf_wen_q, rf_wen_d;
  logic [SELW-1:0]   rf_wsel_q, rf_wsel_d;
  logic [WIDTH-1:0]  rf_wdat_q, rf_wdat_d;

  // ---------------------------------------------------------------------------
  // Handshake and request qualification
  // ---------------------------------------------------------------------------
  logic pipe_req_s;
  logic fifo_empty_s;
  logic lop_ready_s;
  logic lop_hs_s;
  logic lop_keep_s;
  logic pipe_win_s;
  logic pop_s;
  logic push_s;
  logic bypass_s;

  assign pipe_req_s   = pipe_wen && (pipe_wsel != SEL_ZERO);
  assign fifo_empty_s = (count_q == {CW{1'b0}});
  assign lop_ready_s  = !RST && (count_q < DEPTH_C);
  assign lop_hs_s     = lop_valid && lop_ready_s;
  // A handshake to register 0 is consumed and dropped.
  assign lop_keep_s   = lop_hs_s && (lop_rsel != SEL_ZERO);

`ifdef WB_BYPASS_EN
  assign bypass_s = lop_keep_s && fifo_empty_s && (state_q == ST_NORMAL) && !pipe_req_s;
`else
  assign bypass_s = 1'b0;
`endif

  assign push_s = lop_keep_s && !bypass_s;

  // Arbitration: pipeline first in NORMAL, FIFO head first in DRAIN.
  always_comb begin
    pipe_win_s = 1'b0;
    pop_s      = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        if (pipe_req_s) begin
          pipe_win_s = 1'b1;
        end else if (!fifo_empty_s) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (!fifo_empty_s) begin
          pop_s = 1'b1;
        end else begin
          pipe_win_s = pipe_req_s;
        end
      end
      default: begin
        pipe_win_s = 1'b0;
        pop_s      = 1'b0;
      end
    endcase
  end

  // FIFO storage, pointers and occupancy.
  always_comb begin
    fifo_sel_d = fifo_sel_q;
    fifo_dat_d = fifo_dat_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (push_s) begin
      fifo_sel_d[tail_q] = lop_rsel;
      fifo_dat_d[tail_q] = lop_rdat;
      tail_d             = tail_q + PW'(1);
    end else begin
      tail_d = tail_q;
    end
    if (pop_s) begin
      head_d = head_q + PW'(1);
    end else begin
      head_d = head_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Next register-file write; zeroed when no source wins.
  always_comb begin
    rf_wen_d  = 1'b0;
    rf_wsel_d = SEL_ZERO;
    rf_wdat_d = {WIDTH{1'b0}};
    if (pipe_win_s) begin
      rf_wen_d  = 1'b1;
      rf_wsel_d = pipe_wsel;
      rf_wdat_d = pipe_wdat;
    end else if (pop_s) begin
      rf_wen_d  = 1'b1;
      rf_wsel_d = fifo_sel_q[head_q];
      rf_wdat_d = fifo_dat_q[head_q];
    end else if (bypass_s) begin
      rf_wen_d  = 1'b1;
      rf_wsel_d = lop_rsel;
      rf_wdat_d = lop_rdat;
    end else begin
      rf_wen_d  = 1'b0;
    end
  end

  // Scoreboard: clears from pops/bypass first so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (pop_s) begin
      busy_d[fifo_sel_q[head_q]] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (bypass_s) begin
      busy_d[lop_rsel] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (lop_issue && (lop_dest != SEL_ZERO)) begin
      busy_d[lop_dest] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Starvation counter and NORMAL/DRAIN transitions.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      ST_NORMAL: begin
        if (pop_s || fifo_empty_s) begin
          starve_d = {SCW{1'b0}};
        end else if (pipe_win_s) begin
          starve_d = starve_q + SCW'(1);
        end else begin
          starve_d = starve_q;
        end
        // Enter DRAIN on the same edge the counter reaches the limit.
        if (starve_d == STARVE_C) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_NORMAL;
        end
      end
      ST_DRAIN: begin
        if (pop_s) begin
          state_d  = ST_NORMAL;
          starve_d = {SCW{1'b0}};
        end else begin
          state_d  = ST_DRAIN;
        end
      end
      default: begin
        state_d  = ST_NORMAL;
        starve_d = {SCW{1'b0}};
      end
    endcase
  end

  // All state registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_NORMAL;
      starve_q  <= {SCW{1'b0}};
      count_q   <= {CW{1'b0}};
      head_q    <= {PW{1'b0}};
      tail_q    <= {PW{1'b0}};
      for (int i = 0; i < PEND_DEPTH; i++) begin
        fifo_sel_q[i] <= SEL_ZERO;
        fifo_dat_q[i] <= {WIDTH{1'b0}};
      end
      busy_q    <= {NREGS{1'b0}};
      rf_wen_q  <= 1'b0;
      rf_wsel_q <= SEL_ZERO;
      rf_wdat_q <= {WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fifo_sel_q <= fifo_sel_d;
      fifo_dat_q <= fifo_dat_d;
      busy_q     <= busy_d;
      rf_wen_q   <= rf_wen_d;
      rf_wsel_q  <= rf_wsel_d;
      rf_wdat_q  <= rf_wdat_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign lop_ready = lop_ready_s;
  assign stall     = (state_q == ST_DRAIN)
                   || busy_hit(chk_rs, busy_q)
                   || busy_hit(chk_rt, busy_q)
                   || (chk_rd_en && busy_hit(chk_rd, busy_q));
  assign rf_wen    = rf_wen_q;
  assign rf_wsel   = rf_wsel_q;
  assign rf_wdat   = rf_wdat_q;
  assign busy      = busy_q;

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-port arbiter and scoreboard sitting directly upstream of the register file write port.
- Merges two writeback sources into the single register file write port (WEN/wsel/wdat):
  - the in-order pipeline MEM/WB writeback;
  - results from a multicycle long-op unit (mul/div), taken through a valid/ready handshake.
- Keeps a per-register busy scoreboard for long-op destinations and stalls decode on RAW/WAW hazards against pending long-op results.

Parameters:
- NREGS, 32, number of architectural registers; select width is log2(NREGS).
- WIDTH, 32, data width.
- PEND_DEPTH, 2, depth of the long-op result FIFO (power of two, >=2).
- STARVE_MAX, 8, consecutive blocked cycles before a forced drain.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous active-high reset.
- pipe_wen  in  1  pipeline writeback request.
- pipe_wsel  in  5  pipeline destination register.
- pipe_wdat  in  WIDTH  pipeline writeback data.
- lop_issue  in  1  long-op issued this cycle.
- lop_dest  in  5  destination of the issued long-op.
- lop_valid  in  1  long-op result valid.
- lop_ready  out  1  result accepted when lop_valid && lop_ready.
- lop_rsel  in  5  destination of the long-op result.
- lop_rdat  in  WIDTH  long-op result data.
- chk_rs  in  5  decode source 1.
- chk_rt  in  5  decode source 2.
- chk_rd  in  5  decode destination.
- chk_rd_en  in  1  decode instruction writes chk_rd.
- stall  out  1  decode stall.
- rf_wen  out  1  register file write enable.
- rf_wsel  out  5  register file write select.
- rf_wdat  out  WIDTH  register file write data.
- busy  out  NREGS  scoreboard bit vector, for debug and hazard logic.

Behaviour:
- Reset values:
  - rf_wen=0, rf_wsel=0, rf_wdat=0, busy=0.
  - FIFO empty; starve counter=0; state NORMAL.
  - lop_ready=0 while RST is high.
  - Reset mid-operation discards all FIFO entries and busy bits.
- rf_wen/rf_wsel/rf_wdat are registered: a winning source in cycle N appears on rf_* in cycle N+1.
- rf_wen is 0 in any cycle with no winner.
- A pipeline request with pipe_wsel=0 is treated as no request.
- Long-op accept:
  - lop_ready = !RST && (count < PEND_DEPTH).
  - On handshake with lop_rsel!=0, the result is pushed into the FIFO tail.
  - On handshake with lop_rsel=0, the result is consumed and dropped.
- Arbitration:
  - State NORMAL: the pipeline wins when pipe_wen && pipe_wsel!=0. Otherwise a non-empty FIFO head wins and is popped.
  - Push and pop in the same cycle are legal; count is unchanged.
  - No bypass: accept-to-rf_wen minimum latency is 2 cycles.
- Starvation FSM:
  - NORMAL: the counter increments each cycle the FIFO is non-empty and the pipeline wins. It clears on any pop or when the FIFO is empty.
  - NORMAL -> DRAIN: when the counter reaches STARVE_MAX.
  - DRAIN: stall=1. The FIFO head wins over the pipeline.
  - DRAIN -> NORMAL: after one pop; the counter clears.
  - A pipeline request present in DRAIN is held by upstream. stall guarantees no new issue; the MEM/WB stage holds its request while stall=1.
- Scoreboard:
  - lop_issue && lop_dest!=0 sets busy[lop_dest] at the next edge.
  - A pop of a FIFO entry clears busy[entry dest] at the same edge.
  - Set and clear of the same register in the same cycle: set wins.
- stall is combinational:
  - stall = DRAIN || busy[chk_rs] || busy[chk_rt] || (chk_rd_en && busy[chk_rd]).
  - The busy terms apply only to nonzero selects.
  - Upstream never asserts lop_issue while stall=1.
- Register 0 is never written and never busy.

Optional Feature:
- Macro name: WB_BYPASS_EN.
- Defined:
  - An accepted long-op result bypasses the FIFO when the FIFO is empty, state is NORMAL, and the pipeline does not win that cycle.
  - It is written to rf_* at the next edge (latency 1), and busy clears at that edge.
  - count is untouched by a bypassed result.
- Undefined: every result goes through the FIFO (latency >= 2).

Test Plan:
- Reset: assert RST 2 cycles with pipe_wen=1 -> rf_wen=0, busy=0, lop_ready=0. Deassert RST -> lop_ready=1.
- Pipeline-only traffic: pipe_wen=1, wsel=5, wdat=0xDEADBEEF -> next cycle rf_wen=1, rf_wsel=5, rf_wdat=0xDEADBEEF. With wsel=0 -> rf_wen=0.
- Collision:
  - Setup: issue lop_dest=9. Present result (9, 0x1234) while pipe_wen=1 (wsel=3) for 2 cycles.
  - Response: r3 written first; r9 written when pipe_wen drops. busy[9] stays 1 until that write edge.
  - Hazard check: chk_rs=9 stalls during the whole interval.
- FIFO full: hold pipe_wen=1 and present 3 results -> lop_ready=0 after 2 accepts. Third result held until a pop.
- Starvation:
  - Stimulus: FIFO holds 1 entry and pipe_wen=1 continuously.
  - Response: after 8 blocked cycles stall=1 and the FIFO head is written. Next cycle stall=0 (busy clear) and the pipeline is written.
- Bypass (WB_BYPASS_EN defined): empty FIFO, pipe_wen=0, result (7, 0x55) accepted -> rf_wen=1 next cycle, busy[7]=0. Undefined -> write appears 2 cycles after accept.
